// File: rtl/ks_wide_add_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit Kogge-Stone adder is reused
// for every 16-bit slice of a (16*WORDS)-bit operand, LSW first, carry registered between slices.

module ks_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [15:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4;
  logic [15:0] carry;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Prefix levels at spans 1, 2, 4, 8; low bits below the span keep their group terms.
  assign g1 = g0 | (p0 & (g0 << 1));
  assign p1 = p0 & ((p0 << 1) | 16'h0001);
  assign g2 = g1 | (p1 & (g1 << 2));
  assign p2 = p1 & ((p1 << 2) | 16'h0003);
  assign g3 = g2 | (p2 & (g2 << 4));
  assign p3 = p2 & ((p2 << 4) | 16'h000F);
  assign g4 = g3 | (p3 & (g3 << 8));
  assign p4 = p3 & ((p3 << 8) | 16'h00FF);

  // carry[i] is the carry out of bit i including the external carry-in.
  assign carry = g4 | (p4 & {16{ci}});
  assign s     = p0 ^ {carry[14:0], ci};
  assign co    = carry[15];
endmodule

module ks_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SUB,
  input  logic                  CI,
  input  logic [16*WORDS-1:0]   A,
  input  logic [16*WORDS-1:0]   B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [16*WORDS-1:0]   S,
  output logic                  CO,
  output logic                  OV
);
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx;
  logic                      carry;
  logic [WORDS-1:0][15:0]    a_reg, b_reg, s_reg;
  logic                      co_reg, ov_reg;

  logic [15:0]               a_in, b_in, sum;
  logic                      sum_co, last;

  assign a_in = a_reg[idx];
  assign b_in = b_reg[idx];
  assign last = (idx == IDX_W'(WORDS - 1));

  ks_adder16 u_adder (
    .a  (a_in),
    .b  (b_in),
    .ci (carry),
    .s  (sum),
    .co (sum_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand copies need no reset: they are only read while RUN, after a fresh capture.
  always_ff @(posedge CLK) begin
    if (state == IDLE && START) begin
      a_reg <= A;
      b_reg <= SUB ? ~B : B;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      s_reg  <= '0;
      co_reg <= 1'b0;
      ov_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (START) begin
            carry <= SUB ? 1'b1 : CI;
            idx   <= '0;
            s_reg <= '0;
          end
        end
        RUN: begin
          s_reg[idx] <= sum;
          carry      <= sum_co;
          idx        <= idx + 1'b1;
          if (last) begin
            co_reg <= sum_co;
            // Signed overflow: like-signed operands producing a sum of the other sign.
            ov_reg <= (a_in[15] == b_in[15]) && (sum[15] != a_in[15]);
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);
  assign S    = s_reg;
  assign CO   = co_reg;
  assign OV   = ov_reg;
endmodule

// File: tb/tb_ks_wide_add_seq.sv
// Scoreboard bench for ks_wide_add_seq at WORDS=4: directed vectors plus a wide-arithmetic
// reference for a batch of random operations; a monitor checks every DONE against the queue.

module tb_ks_wide_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         CLK, RST, START, SUB, CI;
  logic [W-1:0] A, B, S;
  logic         BUSY, DONE, CO, OV;

  typedef struct {
    string        name;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ks_wide_add_seq #(.WORDS(WORDS)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SUB   (SUB),
    .CI    (CI),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .CO    (CO),
    .OV    (OV)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got DONE=1, required no DONE");
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_S"}, S, e.s);
        check({e.name, "_CO"}, W'(CO), W'(e.co));
        check({e.name, "_OV"}, W'(OV), W'(e.ov));
      end
    end
  end

  // Issue one operation; poke=1 also fires START during RUN (with other operands)
  // and again in the DONE cycle, both of which must be ignored.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic ci, input logic [W-1:0] es,
                       input logic eco, input logic eov, input bit poke);
    int lat;
    bit seen;
    @(negedge CLK);
    A = a; B = b; SUB = sub; CI = ci; START = 1'b1;
    q.push_back('{name, es, eco, eov});
    @(negedge CLK);
    START = 1'b0; A = ~a; B = ~b; SUB = ~sub; CI = ~ci;
    lat = 1;
    check({name, "_busy_after_accept"}, W'(BUSY), W'(1));
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (DONE) begin
        seen = 1'b1;
      end else begin
        if (poke && lat == 2) begin
          START = 1'b1; A = 64'hDEAD_BEEF_1234_5678; B = 64'h1; SUB = 1'b0; CI = 1'b1;
        end else begin
          START = 1'b0;
        end
        @(negedge CLK);
        lat++;
      end
    end
    START = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no DONE in %0d cycles, required DONE", name, lat);
      void'(q.pop_back());
    end else begin
      check({name, "_latency"}, W'(lat), W'(WORDS + 1));
      check({name, "_busy_in_done"}, W'(BUSY), W'(0));
      if (poke) START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check({name, "_done_width"}, W'(DONE), W'(0));
      check({name, "_busy_after_done"}, W'(BUSY), W'(0));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0]      ra, rb;
    logic              rsub, rci;
    logic [W:0]        full;
    logic signed [W+1:0] sr;
    logic              rov;

    RST = 1'b1; START = 1'b0; SUB = 1'b0; CI = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", W'(BUSY), W'(0));
    check("rst_done", W'(DONE), W'(0));
    check("rst_s",    S, '0);
    check("rst_co",   W'(CO), W'(0));
    check("rst_ov",   W'(OV), W'(0));
    RST = 1'b0;

    do_op("ripple_add", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h0, 1'b1, 1'b0, 1'b0);
    do_op("sub_borrow", 64'h0, 64'h1, 1'b1, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    do_op("ci_ignored_start", 64'h0000_0001_0000_FFFF, 64'h0, 1'b0, 1'b1,
          64'h0000_0001_0001_0000, 1'b0, 1'b0, 1'b1);
    do_op("sub_ci_ignored", 64'h5, 64'h3, 1'b1, 1'b1,
          64'h2, 1'b1, 1'b0, 1'b0);
    do_op("sub_signed_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op("ci_full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1,
          64'h0, 1'b1, 1'b0, 1'b0);

    // Abort on the second RUN cycle: slice 0 already written, so S must clear.
    @(negedge CLK);
    A = 64'h1111_2222_3333_4444; B = 64'h0101_0101_0101_0101; SUB = 1'b0; CI = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_busy", W'(BUSY), W'(0));
    check("abort_s",    S, '0);
    check("abort_done", W'(DONE), W'(0));
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("abort_no_done", W'(DONE), W'(0));
    end
    do_op("after_abort", 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0,
          64'h1212_2323_3434_4545, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rsub = 1'($urandom_range(0, 1));
      rci  = 1'($urandom_range(0, 1));
      if (i % 4 == 0) rb = ra;
      if (rsub) begin
        full = {1'b0, ra} + {1'b0, ~rb} + (W+1)'(1);
        sr   = $signed({{2{ra[W-1]}}, ra}) - $signed({{2{rb[W-1]}}, rb});
      end else begin
        full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rci);
        sr   = $signed({{2{ra[W-1]}}, ra}) + $signed({{2{rb[W-1]}}, rb}) + $signed((W+2)'(rci));
      end
      rov = (sr[W+1:W-1] != {3{sr[W-1]}});
      do_op("random", ra, rb, rsub, rci, full[W-1:0], full[W], rov, 1'b0);
    end

    repeat (3) @(negedge CLK);
    check("queue_empty", W'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
